// File: rtl/crc32_stream_appender.sv
// Byte-stream framer: forwards payload bytes and appends a CRC-32 (poly 04C11DB7, MSB-first) after each frame.
// Define CRC32_FINAL_INV_EN to invert the final CRC (BZIP2); default leaves it uninverted (MPEG-2).
`timescale 1ns/1ps

// state  | meaning
// PASS   | forwarding payload bytes, CRC accumulating
// APPEND | emitting the four CRC bytes, input stalled
module crc32_stream_appender #(
   parameter logic [31:0] CRC_INIT = 32'hFFFFFFFF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  s_data,
   input  logic        s_valid,
   input  logic        s_last,
   output logic        s_ready,
   output logic [7:0]  m_data,
   output logic        m_valid,
   output logic        m_last,
   input  logic        m_ready,
   output logic [31:0] crc_out,
   output logic        crc_done
);

   typedef enum logic {PASS = 1'b0, APPEND = 1'b1} state_t;

   state_t      state, state_nxt;
   logic [31:0] crc_reg;
   logic [31:0] crc_next;
   logic [31:0] crc_final;
   logic [1:0]  byte_cnt;
   logic [7:0]  crc_byte;
   logic        out_free;
   logic        in_xfer;

   function automatic logic [31:0] crc_step(input logic [31:0] crc, input logic [7:0] d);
      logic [31:0] c;
      logic        fb;
      c = crc;
      for (int i = 7; i >= 0; i--) begin
         fb = c[31] ^ d[i];
         c  = {c[30:0], 1'b0} ^ (fb ? 32'h04C11DB7 : 32'h0000_0000);
      end
      return c;
   endfunction

   assign out_free = !m_valid || m_ready;
   assign in_xfer  = s_valid && s_ready;
   assign crc_next = crc_step(crc_reg, s_data);

   // The final value includes the last payload byte, so it is taken from the stepped CRC.
`ifdef CRC32_FINAL_INV_EN
   assign crc_final = ~crc_next;
`else
   assign crc_final = crc_next;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= PASS;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         PASS:    if (in_xfer && s_last) state_nxt = APPEND;
         APPEND:  if (out_free && (byte_cnt == 2'd3)) state_nxt = PASS;
         default: state_nxt = PASS;
      endcase
   end

   always_comb begin
      s_ready = (state == PASS) && out_free;
   end

   always_comb begin
      crc_byte = 8'h00;
      case (byte_cnt)
         2'd0: crc_byte = crc_out[31:24];
         2'd1: crc_byte = crc_out[23:16];
         2'd2: crc_byte = crc_out[15:8];
         2'd3: crc_byte = crc_out[7:0];
         default: crc_byte = 8'h00;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         crc_reg  <= CRC_INIT;
         m_data   <= 8'h00;
         m_valid  <= 1'b0;
         m_last   <= 1'b0;
         crc_out  <= 32'h0000_0000;
         crc_done <= 1'b0;
         byte_cnt <= 2'd0;
      end else begin
         crc_done <= 1'b0;
         case (state)
            PASS: begin
               if (in_xfer) begin
                  m_data  <= s_data;
                  m_valid <= 1'b1;
                  m_last  <= 1'b0;
                  crc_reg <= crc_next;
                  if (s_last) begin
                     byte_cnt <= 2'd0;
                     crc_out  <= crc_final;
                     crc_done <= 1'b1;
                  end
               end else if (out_free) begin
                  m_valid <= 1'b0;
                  m_last  <= 1'b0;
               end
            end
            APPEND: begin
               if (out_free) begin
                  m_data   <= crc_byte;
                  m_valid  <= 1'b1;
                  m_last   <= (byte_cnt == 2'd3);
                  byte_cnt <= byte_cnt + 2'd1;
                  if (byte_cnt == 2'd3) begin
                     crc_reg  <= CRC_INIT;
                     byte_cnt <= 2'd0;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_crc32_stream_appender.sv
// Directed bench for crc32_stream_appender: known-answer frames, backpressure, back-to-back and mid-frame reset.
`timescale 1ns/1ps

module tb_crc32_stream_appender;

   typedef struct packed {
      logic [7:0] data;
      logic       last;
   } rec_t;

`ifdef CRC32_FINAL_INV_EN
   localparam logic [31:0] KAT_CRC  = 32'hFC891918;
   localparam logic [31:0] ZERO_CRC = 32'hB1F7404B;
`else
   localparam logic [31:0] KAT_CRC  = 32'h0376E6E7;
   localparam logic [31:0] ZERO_CRC = 32'h4E08BFB4;
`endif

   logic        clk;
   logic        rst;
   logic [7:0]  s_data;
   logic        s_valid;
   logic        s_last;
   logic        s_ready;
   logic [7:0]  m_data;
   logic        m_valid;
   logic        m_last;
   logic        m_ready;
   logic [31:0] crc_out;
   logic        crc_done;

   crc32_stream_appender #(.CRC_INIT(32'hFFFFFFFF)) dut (
      .clk      (clk),
      .rst      (rst),
      .s_data   (s_data),
      .s_valid  (s_valid),
      .s_last   (s_last),
      .s_ready  (s_ready),
      .m_data   (m_data),
      .m_valid  (m_valid),
      .m_last   (m_last),
      .m_ready  (m_ready),
      .crc_out  (crc_out),
      .crc_done (crc_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   rec_t frame_a[9];
   rec_t frame_z[1];
   rec_t out_q[$];
   rec_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   done_cnt = 0;
   logic rand_ready = 1'b0;
   logic       prev_stall = 1'b0;
   logic [7:0] prev_data = 8'h00;
   logic       prev_last = 1'b0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, got, exp);
      end
   endtask

   // Output monitor: records every handshake and checks that stalled outputs hold.
   initial begin : monitor
      rec_t r;
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (prev_stall) begin
               checks++;
               if (!(m_valid === 1'b1 && m_data === prev_data && m_last === prev_last)) begin
                  errors++;
                  $display("FAIL stall_hold: got valid=%b data=%h last=%b, expected valid=1 data=%h last=%b",
                           m_valid, m_data, m_last, prev_data, prev_last);
               end
            end
            if (m_valid && m_ready) begin
               r.data = m_data;
               r.last = m_last;
               out_q.push_back(r);
            end
            if (crc_done) done_cnt++;
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            prev_last  = m_last;
         end else begin
            prev_stall = 1'b0;
         end
      end
   end

   initial begin : ready_driver
      m_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         m_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   initial begin : watchdog
      #300000;
      $display("FAIL watchdog: got no completion, expected finish before 300us");
      $fatal(1, "watchdog expired");
   end

   function automatic rec_t frame_byte(input int sel, input int i);
      return (sel == 0) ? frame_a[i] : frame_z[i];
   endfunction

   function automatic int frame_len(input int sel);
      return (sel == 0) ? 9 : 1;
   endfunction

   task automatic build_exp(input int sel, input logic [31:0] crc, input bit append);
      rec_t        r;
      logic [31:0] c;
      if (!append) exp_q.delete();
      for (int i = 0; i < frame_len(sel); i++) begin
         r      = frame_byte(sel, i);
         r.last = 1'b0;
         exp_q.push_back(r);
      end
      c = crc;
      for (int k = 0; k < 4; k++) begin
         r.data = c[31 - 8*k -: 8];
         r.last = (k == 3);
         exp_q.push_back(r);
      end
   endtask

   task automatic send_byte(input logic [7:0] d, input logic l);
      int t;
      s_data  = d;
      s_valid = 1'b1;
      s_last  = l;
      t = 0;
      forever begin
         @(negedge clk);
         if (s_ready) break;
         t++;
         if (t > 200) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got s_ready=0 for %0d cycles, expected acceptance", t);
            break;
         end
      end
      @(posedge clk);
      #1;
      s_valid = 1'b0;
      s_last  = 1'b0;
   endtask

   task automatic send_frame(input int sel);
      rec_t r;
      for (int i = 0; i < frame_len(sel); i++) begin
         r = frame_byte(sel, i);
         send_byte(r.data, r.last);
      end
   endtask

   task automatic clear_mon();
      @(posedge clk);
      #1;
      out_q.delete();
      done_cnt = 0;
   endtask

   task automatic wait_and_compare(input string name);
      int t;
      t = 0;
      while (out_q.size() < exp_q.size() && t < 1000) begin
         @(negedge clk);
         t++;
      end
      repeat (8) @(negedge clk);
      chk({name, "_count"}, 32'(out_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size(); i++) begin
         if (i >= out_q.size()) break;
         checks++;
         if (out_q[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL %s byte %0d: got %h last=%b, expected %h last=%b",
                     name, i, out_q[i].data, out_q[i].last, exp_q[i].data, exp_q[i].last);
         end
      end
   endtask

   initial begin : main
      for (int i = 0; i < 9; i++) begin
         frame_a[i].data = 8'h31 + 8'(i);
         frame_a[i].last = (i == 8);
      end
      frame_z[0] = '{data: 8'h00, last: 1'b1};

      rst     = 1'b1;
      s_data  = 8'h00;
      s_valid = 1'b0;
      s_last  = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("reset_m_valid",  32'(m_valid),  32'd0);
      chk("reset_m_data",   32'(m_data),   32'd0);
      chk("reset_m_last",   32'(m_last),   32'd0);
      chk("reset_crc_out",  crc_out,       32'd0);
      chk("reset_crc_done", 32'(crc_done), 32'd0);
      chk("reset_s_ready",  32'(s_ready),  32'd1);

      // s_last without s_valid must not produce anything
      clear_mon();
      s_last = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      s_last = 1'b0;
      repeat (4) @(negedge clk);
      chk("lone_last_outputs", 32'(out_q.size()), 32'd0);
      chk("lone_last_done",    32'(done_cnt),     32'd0);

      clear_mon();
      build_exp(0, KAT_CRC, 1'b0);
      send_frame(0);
      wait_and_compare("kat");
      chk("kat_crc_out", crc_out, KAT_CRC);
      chk("kat_done_cnt", 32'(done_cnt), 32'd1);

      clear_mon();
      build_exp(1, ZERO_CRC, 1'b0);
      send_frame(1);
      wait_and_compare("one_byte");
      chk("one_byte_crc_out", crc_out, ZERO_CRC);
      chk("one_byte_done_cnt", 32'(done_cnt), 32'd1);

      clear_mon();
      rand_ready = 1'b1;
      build_exp(0, KAT_CRC, 1'b0);
      send_frame(0);
      wait_and_compare("backpressure");
      rand_ready = 1'b0;
      chk("backpressure_crc_out", crc_out, KAT_CRC);

      clear_mon();
      build_exp(0, KAT_CRC, 1'b0);
      build_exp(0, KAT_CRC, 1'b1);
      send_frame(0);
      send_frame(0);
      wait_and_compare("back_to_back");
      chk("b2b_crc_out", crc_out, KAT_CRC);
      chk("b2b_done_cnt", 32'(done_cnt), 32'd2);

      // Reset after the 4th payload byte; nothing from the partial frame may surface.
      clear_mon();
      for (int i = 0; i < 4; i++) send_byte(frame_a[i].data, 1'b0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("midrst_m_valid", 32'(m_valid), 32'd0);
      chk("midrst_crc_out", crc_out, 32'd0);
      clear_mon();
      build_exp(0, KAT_CRC, 1'b0);
      send_frame(0);
      wait_and_compare("mid_reset");
      chk("midrst_final_crc", crc_out, KAT_CRC);
      chk("midrst_done_cnt", 32'(done_cnt), 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
